ps2_host_tx: RTL



---
 rtl/ps2_host_tx.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset)
// to a PS/2 keyboard over the shared open-drain clock and data lines. The block
// never drives a line high. It only asserts active-high pull-down enables, and
// the top level maps these onto the tri-state pins.
//
// Sequence: hold PS2_CLK low (inhibit), pull PS2_DAT low (start bit), and
// release PS2_CLK. Then shift out 8 data bits LSB first, the odd parity bit and
// the stop bit, one on each device-generated falling edge. Sample the device
// ACK, and wait for both lines to return high.
//
// Optional feature macro: PS2_TX_TIMEOUT_EN
//   When defined, a watchdog aborts a transfer with an error pulse if the device
//   stays silent for TIMEOUT_CYCLES. When undefined, no watchdog logic exists.
//
// Parameters
//   INHIBIT_CYCLES  clock cycles PS2_CLK is held low before the start bit
//   TIMEOUT_CYCLES  watchdog limit (used only with PS2_TX_TIMEOUT_EN)
//
// Ports
//   clock         system clock
//   reset         synchronous, active-high reset
//   tx_data       command byte, sampled when tx_valid && tx_ready
//   tx_valid      request to send tx_data
//   tx_ready      high only while idle
//   ps2_clk_in    raw PS2_CLK pin level (asynchronous)
//   ps2_dat_in    raw PS2_DAT pin level (asynchronous)
//   ps2_clk_pull  1 = drive PS2_CLK low, 0 = release
//   ps2_dat_pull  1 = drive PS2_DAT low, 0 = release
//   done          one-cycle pulse: byte acknowledged by the device
//   error         one-cycle pulse: NACK (or timeout)
//   busy          high in every state except idle

`timescale 1ns/1ps

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_pull,
    output logic       ps2_dat_pull,
    output logic       done,
    output logic       error,
    output logic       busy
);

    // Reject configurations that would make the counters meaningless.
    if (INHIBIT_CYCLES < 1) begin : g_bad_inhibit
        $error("ps2_host_tx: INHIBIT_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("ps2_host_tx: TIMEOUT_CYCLES must be at least 1");
    end

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQUEST,
        S_SEND,
        S_ACK,
        S_WAIT_LINE
    } state_t;

    state_t           state_q,    state_d;
    logic             clk_s1_q,   clk_s1_d;
    logic             clk_s2_q,   clk_s2_d;
    logic             clk_prev_q, clk_prev_d;
    logic             dat_s1_q,   dat_s1_d;
    logic             dat_s2_q,   dat_s2_d;
    logic [INH_W-1:0] inh_cnt_q,  inh_cnt_d;
    logic [3:0]       bit_cnt_q,  bit_cnt_d;
    logic [8:0]       shift_q,    shift_d;    // {parity, data}, shifted out LSB first
    logic             clk_pull_q, clk_pull_d;
    logic             dat_pull_q, dat_pull_d;
    logic             done_q,     done_d;
    logic             error_q,    error_d;
    logic             tx_ready_q, tx_ready_d;
    logic             busy_q,     busy_d;
    logic             fe;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]  wd_cnt_q,   wd_cnt_d;
`endif

    // Falling edge of the synchronised device clock.
    assign fe = clk_prev_q & ~clk_s2_q;

    // NOTE: every *_d gets a default at the top, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        clk_s1_d   = ps2_clk_in;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        dat_s1_d   = ps2_dat_in;
        dat_s2_d   = dat_s1_q;
        inh_cnt_d  = inh_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        clk_pull_d = clk_pull_q;
        dat_pull_d = dat_pull_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
        wd_cnt_d   = wd_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shift_d    = {~^tx_data, tx_data};   // odd parity on top
                    clk_pull_d = 1'b1;
                    inh_cnt_d  = '0;
                    state_d    = S_INHIBIT;
                end
            end

            // Device edges cannot occur while the clock is held low, so the
            // edge detector is ignored here.
            S_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    dat_pull_d = 1'b1;                 // start bit
                    state_d    = S_REQUEST;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end

            S_REQUEST: begin
                clk_pull_d = 1'b0;
                bit_cnt_d  = '0;
                state_d    = S_SEND;
`ifdef PS2_TX_TIMEOUT_EN
                wd_cnt_d   = '0;
`endif
            end

            // Edges 1..9 present data bits 0..7 and parity. Edge 10 releases
            // the data line, which is the stop bit.
            S_SEND: begin
                if (fe) begin
                    if (bit_cnt_q == 4'd9) begin
                        dat_pull_d = 1'b0;
                        state_d    = S_ACK;
                    end else begin
                        dat_pull_d = ~shift_q[0];
                        shift_d    = {1'b0, shift_q[8:1]};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                    end
                end
            end

            S_ACK: begin
                if (fe) begin
                    if (dat_s2_q) begin
                        error_d = 1'b1;                // device did not pull ACK low
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_LINE;
                    end
                end
            end

            S_WAIT_LINE: begin
                if (clk_s2_q && dat_s2_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                clk_pull_d = 1'b0;
                dat_pull_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // The watchdog overrides every other decision, including a done that
        // would fire in the same cycle, so done and error stay exclusive.
        if (state_q == S_SEND || state_q == S_ACK || state_q == S_WAIT_LINE) begin
            if (wd_cnt_q == TO_LAST) begin
                clk_pull_d = 1'b0;
                dat_pull_d = 1'b0;
                done_d     = 1'b0;
                error_d    = 1'b1;
                wd_cnt_d   = '0;
                state_d    = S_IDLE;
            end else if (state_q == S_ACK && state_d != S_ACK) begin
                wd_cnt_d   = '0;
            end else begin
                wd_cnt_d   = wd_cnt_q + TO_W'(1);
            end
        end
`endif

        tx_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    // NOTE: sequential state is written only with non-blocking assignments,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            clk_s1_q   <= 1'b1;     // idle bus level, avoids a false edge
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            inh_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            clk_pull_q <= 1'b0;
            dat_pull_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            clk_prev_q <= clk_prev_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            inh_cnt_q  <= inh_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            clk_pull_q <= clk_pull_d;
            dat_pull_q <= dat_pull_d;
            done_q     <= done_d;
            error_q    <= error_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt_q   <= wd_cnt_d;
`endif
        end
    end

    assign tx_ready     = tx_ready_q;
    assign busy         = busy_q;
    assign ps2_clk_pull = clk_pull_q;
    assign ps2_dat_pull = dat_pull_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule
